// File: rtl/spi_ram_burst.sv
// spi_ram_burst: SPI command decoder over a single-port RAM with burst auto-increment, optional output register and error flags
module spi_ram_burst #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1,
  parameter int OUT_REG   = 0
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 addr_err,
  output logic                 seq_err
);
  localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH - 1);
  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload, wr_addr, rd_addr, wr_next, rd_next, rd_data;
  logic                 in_range, rd_armed, rd_fire, rd_valid, wr_fire;
  assign cmd      = din[ADDR_SIZE+1:ADDR_SIZE];
  assign payload  = din[ADDR_SIZE-1:0];
  assign in_range = {1'b0, payload} < DEPTH;
  assign wr_fire  = !rst && rx_valid && cmd == 2'b01;
  assign rd_fire  = rx_valid && cmd == 2'b11 && rd_armed;
  always_comb begin
    wr_next = (AUTO_INC != 0) ? ((wr_addr == LAST) ? '0 : wr_addr + 1'b1) : wr_addr;
    rd_next = (AUTO_INC != 0) ? ((rd_addr == LAST) ? '0 : rd_addr + 1'b1) : rd_addr;
  end
  // memory is deliberately left out of reset so its contents survive it
  always_ff @(posedge CLK)
    if (wr_fire) mem[wr_addr] <= payload;
  always_ff @(posedge CLK)
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_armed <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      addr_err <= rx_valid && !cmd[0] && !in_range;
      seq_err  <= rx_valid && cmd == 2'b11 && !rd_armed;
      if (rd_fire) begin
        rd_data <= mem[rd_addr];
        rd_addr <= rd_next;
      end
      if (rx_valid && cmd == 2'b00 && in_range) wr_addr <= payload;
      if (rx_valid && cmd == 2'b01) wr_addr <= wr_next;
      if (rx_valid && cmd == 2'b10 && in_range) begin
        rd_addr  <= payload;
        rd_armed <= 1'b1;
      end
    end
  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge CLK)
      if (rst) begin
        dout     <= '0;
        tx_valid <= 1'b0;
      end else begin
        tx_valid <= rd_valid;
        if (rd_valid) dout <= rd_data;
      end
  end else begin : g_direct
    assign dout     = rd_data;
    assign tx_valid = rd_valid;
  end
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: directed checks of three configurations with a latency-aware read scoreboard
module tb_spi_ram_burst;
  typedef struct {int k; logic [7:0] d; int due;} exp_t;
  logic       clk;
  logic [9:0] din  [3];
  logic       rxv  [3];
  logic       rst  [3];
  logic [7:0] dout [3];
  logic       tx   [3];
  logic       ae   [3];
  logic       se   [3];
  exp_t       sb[$];
  int         cyc = 0, tests = 0, fails = 0;
  spi_ram_burst u0 (.CLK(clk), .rst(rst[0]), .din(din[0]), .rx_valid(rxv[0]), .dout(dout[0]),
                    .tx_valid(tx[0]), .addr_err(ae[0]), .seq_err(se[0]));
  spi_ram_burst #(.MEM_DEPTH(200)) u1 (.CLK(clk), .rst(rst[1]), .din(din[1]), .rx_valid(rxv[1]),
                    .dout(dout[1]), .tx_valid(tx[1]), .addr_err(ae[1]), .seq_err(se[1]));
  spi_ram_burst #(.AUTO_INC(0), .OUT_REG(1)) u2 (.CLK(clk), .rst(rst[2]), .din(din[2]), .rx_valid(rxv[2]),
                    .dout(dout[2]), .tx_valid(tx[2]), .addr_err(ae[2]), .seq_err(se[2]));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 3; k++)
      if (tx[k] === 1'b1) begin
        if (sb.size() != 0 && sb[0].k == k) begin
          e = sb.pop_front();
          check($sformatf("u%0d_rd_cycle", k), cyc, e.due);
          check($sformatf("u%0d_rd_dout", k), dout[k], e.d);
        end else check($sformatf("u%0d_unexpected_tx", k), tx[k], 0);
      end else if (sb.size() != 0 && sb[0].k == k && sb[0].due <= cyc) begin
        check($sformatf("u%0d_missing_tx", k), tx[k], 1);
        sb.delete(0);
      end
  end
  task automatic send(input int k, input logic [1:0] c, input logic [7:0] p);
    din[k] = {c, p};
    rxv[k] = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic read(input int k, input logic [7:0] d);
    sb.push_back('{k: k, d: d, due: cyc + ((k == 2) ? 2 : 1)});
    send(k, 2'b11, 8'h00);
  endtask
  task automatic idle(input int k, input int n);
    rxv[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      rxv[k] = 1'b0;
      din[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      check($sformatf("u%0d_rst_dout", k), dout[k], 0);
      check($sformatf("u%0d_rst_tx", k), tx[k], 0);
      check($sformatf("u%0d_rst_addr_err", k), ae[k], 0);
      check($sformatf("u%0d_rst_seq_err", k), se[k], 0);
    end
    // read-data with nothing armed
    send(0, 2'b11, 8'h00);
    check("seq_err_pulse", se[0], 1);
    check("seq_err_no_tx", tx[0], 0);
    idle(0, 1);
    check("seq_err_clear", se[0], 0);
    send(0, 2'b00, 8'd2);   send(0, 2'b01, 8'h33);
    send(0, 2'b00, 8'd100); send(0, 2'b01, 8'hA9);
    send(0, 2'b10, 8'd2);   read(0, 8'h33);
    idle(0, 2);
    send(0, 2'b10, 8'd100); read(0, 8'hA9);
    idle(0, 2);
    // burst write across the FF->00 wrap, then back-to-back reads
    send(0, 2'b00, 8'hFE);
    send(0, 2'b01, 8'h11); send(0, 2'b01, 8'h22); send(0, 2'b01, 8'h33);
    send(0, 2'b10, 8'hFE);
    read(0, 8'h11); read(0, 8'h22); read(0, 8'h33);
    idle(0, 2);
    send(0, 2'b10, 8'h00); read(0, 8'h33);
    idle(0, 2);
    // read immediately after a write to the same address
    send(0, 2'b10, 8'h60); send(0, 2'b00, 8'h60); send(0, 2'b01, 8'hC3); read(0, 8'hC3);
    idle(0, 2);
    // out-of-range addresses on a 200-deep RAM
    send(1, 2'b00, 8'd10);
    send(1, 2'b00, 8'hC8);
    check("wr_addr_err_pulse", ae[1], 1);
    send(1, 2'b01, 8'h77);
    check("addr_err_clear", ae[1], 0);
    send(1, 2'b10, 8'd10);
    send(1, 2'b10, 8'hC8);
    check("rd_addr_err_pulse", ae[1], 1);
    read(1, 8'h77);
    idle(1, 2);
    send(1, 2'b00, 8'd199); send(1, 2'b01, 8'h44); send(1, 2'b01, 8'h55);
    check("wrap_no_err", ae[1], 0);
    send(1, 2'b10, 8'd0); read(1, 8'h55);
    send(1, 2'b10, 8'd199); read(1, 8'h44);
    idle(1, 2);
    // output register, no auto-increment
    send(2, 2'b00, 8'd5); send(2, 2'b01, 8'h5E); send(2, 2'b10, 8'd5);
    read(2, 8'h5E); read(2, 8'h5E);
    idle(2, 3);
    send(2, 2'b01, 8'h6F); read(2, 8'h6F);
    idle(2, 3);
    // reset lands while a read is still in the output stage
    send(2, 2'b11, 8'h00);
    rst[2] = 1'b1;
    rxv[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    check("midrd_rst_tx", tx[2], 0);
    check("midrd_rst_dout", dout[2], 0);
    idle(2, 3);
    check("midrd_tx_quiet", tx[2], 0);
    send(2, 2'b10, 8'd5); read(2, 8'h6F);
    idle(2, 3);
    send(0, 2'b00, 8'hAA); idle(0, 1);
    send(0, 2'b01, 8'hF0); idle(0, 2);
    send(0, 2'b10, 8'hAA); idle(0, 1);
    read(0, 8'hF0);
    idle(0, 3);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
